// File: rtl/main_2a_pkg.sv
// main_2a_pkg: shared widths, address split, block types and memory power-up image.
package main_2a_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int NUM_LINES = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int MEM_WORDS = 256;
  localparam int OFF_W = 2;
  localparam int WORD_W = 2;
  localparam int IDX_W = 2;
  localparam int TAG_W = 4;
  localparam int BLK_W = TAG_W + IDX_W;
  localparam logic [DATA_W-1:0] INIT_W0 = 32'h0000_3CC3;
  localparam logic [DATA_W-1:0] INIT_W128 = 32'h0000_0CCC;
  localparam logic [DATA_W-1:0] INIT_W192 = 32'h0000_00C3;
  typedef logic [DATA_W-1:0] wordT;
  typedef wordT [WORDS_PER_LINE-1:0] blockT;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [WORD_W-1:0] word;
    logic [OFF_W-1:0] off;
  } addrT;
endpackage

// File: rtl/main_2a_if.sv
// main_2a_if: request/response bus between a requester and the cache.
interface main_2a_if;
  import main_2a_pkg::*;
  logic isRead;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic isHit;
  modport master (output isRead, address, writeData, input readData, isHit);
  modport slave (input isRead, address, writeData, output readData, isHit);
endinterface

// File: rtl/main_memory.sv
// main_memory: word array with whole-block write port and combinational block read port.
module main_memory
  import main_2a_pkg::*;
(
  input  logic             clk,
  input  logic             wrEn,
  input  logic [BLK_W-1:0] wrBlk,
  input  blockT            wrData,
  input  logic [BLK_W-1:0] rdBlk,
  output blockT            rdData
);
  wordT mem [0:MEM_WORDS-1] = '{0: INIT_W0, 128: INIT_W128, 192: INIT_W192, default: '0};
  always_ff @(posedge clk)
    if (wrEn)
      for (int i = 0; i < WORDS_PER_LINE; i++) mem[{wrBlk, WORD_W'(i)}] <= wrData[i];
  // Victim and refill blocks always differ on a miss, so the read sees pre-edge contents safely.
  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_rd
    assign rdData[g] = mem[{rdBlk, WORD_W'(g)}];
  end
endmodule

// File: rtl/main_2a.sv
// main_2a: direct-mapped write-back, write-allocate cache completing one request per clock.
module main_2a
  import main_2a_pkg::*;
(
  input logic      clk,
  input logic      rst,
  main_2a_if.slave bus
);
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [NUM_LINES];
  blockT lines [NUM_LINES];
  addrT a;
  logic hit, evict;
  blockT refill, cur, upd;
  logic [OFF_W-1:0] unusedOff;
  assign a = bus.address;
  assign unusedOff = a.off;
  always_comb begin
    hit = valid[a.idx] && tags[a.idx] == a.tag;
    evict = !hit && valid[a.idx] && dirty[a.idx];
    cur = hit ? lines[a.idx] : refill;
    upd = cur;
    upd[a.word] = bus.isRead ? cur[a.word] : bus.writeData;
  end
  main_memory mem (
    .clk(clk),
    .wrEn(evict),
    .wrBlk({tags[a.idx], a.idx}),
    .wrData(lines[a.idx]),
    .rdBlk({a.tag, a.idx}),
    .rdData(refill)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      dirty <= '0;
      bus.readData <= '0;
      bus.isHit <= 1'b0;
    end else begin
      valid[a.idx] <= 1'b1;
      dirty[a.idx] <= (hit && dirty[a.idx]) || !bus.isRead;
      bus.isHit <= hit;
      if (bus.isRead) bus.readData <= cur[a.word];
    end
  // Tag and data need no reset: they are meaningless while the line is invalid.
  always_ff @(posedge clk) begin
    tags[a.idx] <= a.tag;
    lines[a.idx] <= upd;
  end
endmodule

// File: tb/tb_main_2a.sv
// tb_main_2a: directed plus randomized checks of main_2a against a memory-level reference model.
module tb_main_2a;
  import main_2a_pkg::*;
  logic clk = 0;
  logic rst = 0;
  main_2a_if bus();
  main_2a uut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic hit;
    logic [31:0] data;
    string name;
  } expT;
  expT sb[$];
  int total = 0;
  int bad = 0;

  // Model: arch is what a program sees, phys is what backing memory holds.
  logic [31:0] arch [256];
  logic [31:0] phys [256];
  logic [3:0] resTag [4];
  logic resV [4];
  logic resDirty [4];
  logic [31:0] lastRd;

  function automatic void modelInit();
    for (int i = 0; i < 256; i++) begin
      phys[i] = i == 0 ? 32'h3CC3 : i == 128 ? 32'hCCC : i == 192 ? 32'hC3 : 32'h0;
      arch[i] = phys[i];
    end
    for (int i = 0; i < 4; i++) begin
      resV[i] = 0;
      resDirty[i] = 0;
      resTag[i] = 0;
    end
    lastRd = 0;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      if (resV[i] && resDirty[i])
        for (int k = 0; k < 4; k++) arch[int'(resTag[i]) * 16 + i * 4 + k] = phys[int'(resTag[i]) * 16 + i * 4 + k];
      resV[i] = 0;
      resDirty[i] = 0;
    end
    lastRd = 0;
  endfunction

  function automatic void modelReq(input logic rd, input logic [9:0] addr, input logic [31:0] wd,
                                   output logic h, output logic [31:0] d);
    int w = int'(addr[9:2]);
    int idx = int'(addr[5:4]);
    logic [3:0] tg = addr[9:6];
    h = resV[idx] && resTag[idx] == tg;
    if (!h) begin
      if (resV[idx] && resDirty[idx])
        for (int k = 0; k < 4; k++) phys[int'(resTag[idx]) * 16 + idx * 4 + k] = arch[int'(resTag[idx]) * 16 + idx * 4 + k];
      resV[idx] = 1;
      resTag[idx] = tg;
      resDirty[idx] = 0;
    end
    if (rd) lastRd = arch[w];
    else begin
      arch[w] = wd;
      resDirty[idx] = 1;
    end
    d = lastRd;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic req(input logic rd, input logic [9:0] addr, input logic [31:0] wd, input string nm,
                     input bit useConst = 0, input logic ch = 0, input logic [31:0] cd = 0);
    logic h;
    logic [31:0] d;
    expT e;
    bus.isRead = rd;
    bus.address = addr;
    bus.writeData = wd;
    modelReq(rd, addr, wd, h, d);
    e.hit = useConst ? ch : h;
    e.data = useConst ? cd : d;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic midReset(input string nm);
    #2 rst = 1;
    #1 check({nm, ".readData"}, bus.readData, 32'h0);
    check({nm, ".isHit"}, {31'h0, bus.isHit}, 32'h0);
    modelReset();
    @(negedge clk);
    rst = 0;
  endtask

  always @(posedge clk) begin
    expT e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, ".isHit"}, {31'h0, bus.isHit}, {31'h0, e.hit});
      check({e.name, ".readData"}, bus.readData, e.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] tg;
    modelInit();
    bus.isRead = 1;
    bus.address = '0;
    bus.writeData = '0;
    #2 rst = 1;
    repeat (2) @(negedge clk);
    check("rst.readData", bus.readData, 32'h0);
    check("rst.isHit", {31'h0, bus.isHit}, 32'h0);
    rst = 0;
    req(1, 10'h000, 0, "rd0.cold", 1, 0, 32'h3CC3);
    req(0, 10'h000, 32'hFF, "wr0.hit", 1, 1, 32'h3CC3);
    check("mem0.noWriteThrough", uut.mem.mem[0], 32'h3CC3);
    req(1, 10'h000, 0, "rd0.hit", 1, 1, 32'hFF);
    req(1, 10'h200, 0, "rd200.evict", 1, 0, 32'hCCC);
    check("mem0.writeBack", uut.mem.mem[0], 32'hFF);
    req(1, 10'h000, 0, "rd0.again", 1, 0, 32'hFF);
    req(1, 10'h300, 0, "rd300", 1, 0, 32'hC3);
    req(1, 10'h200, 0, "rd200.again", 1, 0, 32'hCCC);
    req(0, 10'h000, 32'h55, "wr0.alloc", 1, 0, 32'hCCC);
    bus.isRead = 1;
    bus.address = 10'h000;
    midReset("dirtyRst");
    req(1, 10'h000, 0, "rd0.postRst", 1, 0, 32'hFF);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) midReset("rndRst");
      tg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      req(1'($urandom), {tg, 2'($urandom), 2'($urandom), 2'($urandom)}, $urandom, "rnd");
    end
    for (int i = 0; i < 256; i++) check("memImage", uut.mem.mem[i], phys[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/main_2a.md
MAIN_2A -- requirements
Module: main_2a

Interface
REQ-001 ADDR_W, 10, byte address width.
REQ-002 DATA_W, 32, word width.
REQ-003 NUM_LINES, 4, cache lines (direct mapped).
REQ-004 WORDS_PER_LINE, 4, words per cache block.
REQ-005 MEM_WORDS, 256, main-memory depth in words.
REQ-006 Clocking SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-007 clk  input  1  system clock, rising-edge active.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 isRead  input  1  1 = read request, 0 = write request.
REQ-010 address  input  ADDR_W  byte address, word aligned (bits[1:0] ignored).
REQ-011 writeData  input  DATA_W  data for write requests.
REQ-012 readData  output  DATA_W  registered read result.
REQ-013 isHit  output  1  registered hit flag of the last request.

Function
REQ-014 A request SHALL be presented every cycle and SHALL be sampled and fully completed on each rising clk edge; there is no handshake and no stall.
REQ-015 Address split SHALL be: [1:0] byte offset, [3:2] word-in-block, [5:4] index, [9:6] tag.
REQ-016 Each line SHALL hold valid, dirty, a 4-bit tag and 4 data words.
REQ-017 Hit SHALL be defined as valid[index] and tag match; isHit SHALL be registered as 1 on hit and 0 on miss.
REQ-018 Read hit: readData SHALL be the cached word; memory SHALL be untouched.
REQ-019 Write hit: the cached word SHALL be updated, dirty SHALL be set, memory SHALL NOT be written (write-back).
REQ-020 Miss with valid and dirty victim: the whole victim block SHALL be written to memory at {old tag, index}.
REQ-021 Miss: the block SHALL be refilled from memory, with tag stored, valid = 1 and dirty = 0, all within the same edge.
REQ-022 A write miss SHALL allocate the block (write-allocate), then apply the write and set dirty.
REQ-023 readData after a write SHALL hold its previous value.
REQ-024 Main memory SHALL be word indexed by address[9:2] and SHALL power up with word 0 = 0x00003CC3, word 128 = 0x00000CCC, word 192 = 0x000000C3 and all other words 0.
REQ-025 The write-back of REQ-020 SHALL occur before the refill read of REQ-021 in the same edge.

Reset
REQ-026 On rst assertion, immediately and independent of clk: all valid and dirty bits SHALL be 0, readData SHALL be 0 and isHit SHALL be 0.
REQ-027 Reset SHALL NOT alter main-memory contents; dirty data lost at reset SHALL be discarded.
REQ-028 The first request after reset deassertion SHALL be serviced on the next rising edge.

Structure
REQ-029 Address field widths, the line/word counts and the memory init constants SHALL live in a shared package.
REQ-030 Main memory SHALL be one sub-module, main_memory, instantiated as mem with its array named mem[0:MEM_WORDS-1], so that benches can probe uut.mem.mem[i].
REQ-031 Cache arrays and control SHALL be implemented in main_2a.

Verification
REQ-032 After reset, read 0x000 -> isHit = 0, readData = 0x00003CC3.
REQ-033 Then write 0x000 with 0xFF -> isHit = 1; mem[0] stays 0x00003CC3.
REQ-034 Then read 0x000 -> isHit = 1, readData = 0x000000FF.
REQ-035 Then read 0x200 -> isHit = 0, readData = 0x00000CCC, mem[0] = 0x000000FF.
REQ-036 Then read 0x000 -> miss, readData = 0xFF; read 0x300 -> miss, readData = 0xC3; read 0x200 -> miss, readData = 0xCCC.
REQ-037 Assert rst mid-sequence with a dirty line -> outputs 0 at once; the next read of the same address misses and returns the memory value.
